// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam logic        RstEnable  = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_mc_counter.sv
// Loadable down-counter for multi-cycle EX ops; registers the done/abort pulses.
module pipe_mc_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    input  logic         kill,
    output logic [W-1:0] cnt,
    output logic         done,
    output logic         abort
);

    // Kill beats load beats run; the terminal-count compare fires done one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            cnt   <= '0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            if (kill) begin
                cnt   <= '0;
                abort <= 1'b1;
            end else if (load) begin
                cnt  <= load_val;
                done <= (load_val == '0);
            end else if (run && cnt != '0) begin
                cnt  <= cnt - W'(1);
                done <= (cnt == W'(1));
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, multi-cycle EX sequencing, exception flush.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | normal flow; stall follows stage requests
// ST_MC_BUSY | multi-cycle EX op in progress; pc..ex held
// ST_FLUSH   | exception redirect; flush and new_pc asserted
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LEN_W     = 6,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                excp_req,
    input  logic [31:0]         excp_pc,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                ex_mc_done,
    output logic                ex_mc_abort,
    output logic                busy
);

    pipe_state_e         state, state_nxt;
    logic [1:0]          flush_cnt;
    logic [MC_LEN_W-1:0] mc_cnt;
    logic [MC_LEN_W-1:0] mc_len_m1;
    logic                excp_take;
    logic                mc_load;
    logic                mc_kill;
    logic                mc_run;

    // A zero length is treated as a one-cycle op.
    assign mc_len_m1 = (ex_mc_len == '0) ? '0 : ex_mc_len - MC_LEN_W'(1);
    assign excp_take = excp_req && (state != ST_FLUSH);
    assign mc_load   = ex_mc_start && !excp_req && (state == ST_IDLE);
    assign mc_kill   = excp_take && ((state == ST_MC_BUSY) || ex_mc_start);
    assign mc_run    = (state == ST_MC_BUSY) && !excp_req;

    pipe_mc_counter #(.W(MC_LEN_W)) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (mc_load),
        .load_val (mc_len_m1),
        .run      (mc_run),
        .kill     (mc_kill),
        .cnt      (mc_cnt),
        .done     (ex_mc_done),
        .abort    (ex_mc_abort)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) state <= ST_IDLE;
        else                  state <= state_nxt;
    end

    // Next-state and stall mux; an exception always overrides any hold.
    always_comb begin
        state_nxt = state;
        stall     = STALL_NONE;
        case (state)
            ST_IDLE: begin
                if (excp_req) begin
                    state_nxt = ST_FLUSH;
                end else if (ex_mc_start) begin
                    stall = STALL_EX;
                    if (mc_len_m1 != '0) state_nxt = ST_MC_BUSY;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_id) begin
                    stall = STALL_ID;
                end
            end
            ST_MC_BUSY: begin
                if (excp_req) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    stall = STALL_EX;
                    if (mc_cnt == MC_LEN_W'(1)) state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 2'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Flush length counter and redirect target; new_pc keeps its value after the flush.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            flush_cnt <= 2'd0;
            new_pc    <= ZeroWord;
        end else if (excp_take) begin
            flush_cnt <= 2'(FLUSH_CYCLES - 1);
            new_pc    <= excp_pc;
        end else if (state == ST_FLUSH && flush_cnt != 2'd0) begin
            flush_cnt <= flush_cnt - 2'd1;
        end
    end

    assign flush = (state == ST_FLUSH);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-count reference model.
module tb_pipe_ctrl;

    localparam int FC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, ex_mc_start, excp_req;
    logic [5:0]  ex_mc_len;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush, ex_mc_done, ex_mc_abort, busy;
    logic [31:0] new_pc;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining hold cycles and remaining flush cycles.
    int          mc_left, fl_left;
    logic [31:0] m_pc;
    logic        m_done, m_abort;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_LEN_W(6), .FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .ex_mc_start (ex_mc_start),
        .ex_mc_len   (ex_mc_len),
        .excp_req    (excp_req),
        .excp_pc     (excp_pc),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .ex_mc_done  (ex_mc_done),
        .ex_mc_abort (ex_mc_abort),
        .busy        (busy)
    );

    task automatic model_reset();
        mc_left = 0; fl_left = 0; m_pc = 32'h0; m_done = 1'b0; m_abort = 1'b0;
    endtask

    function automatic logic [5:0] model_stall();
        if (fl_left > 0 || excp_req)          return 6'b000000;
        if (mc_left > 0 || ex_mc_start)       return 6'b001111;
        if (stallreq_ex)                      return 6'b001111;
        if (stallreq_id)                      return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic model_update();
        int len;
        m_done = 1'b0; m_abort = 1'b0;
        if (fl_left > 0) begin
            fl_left--;
        end else if (excp_req) begin
            fl_left = FC;
            m_pc    = excp_pc;
            m_abort = (mc_left > 0) || ex_mc_start;
            mc_left = 0;
        end else if (mc_left > 0) begin
            mc_left--;
            if (mc_left == 0) m_done = 1'b1;
        end else if (ex_mc_start) begin
            len = (ex_mc_len == 0) ? 1 : int'(ex_mc_len);
            if (len == 1) m_done = 1'b1;
            else          mc_left = len - 1;
        end
    endtask

    function automatic logic [35:0] model_regs();
        return {fl_left > 0, m_pc, m_done, m_abort, (fl_left > 0) || (mc_left > 0)};
    endfunction

    // Drive one cycle of inputs, advance the model and return observed/expected values.
    task automatic run_cycle(input logic id, input logic ex, input logic st, input logic [5:0] len,
                             input logic xr, input logic [31:0] xpc,
                             output logic [5:0] os, output logic [5:0] es,
                             output logic [35:0] orr, output logic [35:0] er);
        stallreq_id = id; stallreq_ex = ex; ex_mc_start = st; ex_mc_len = len;
        excp_req = xr; excp_pc = xpc;
        @(negedge clk);
        os = stall;
        es = model_stall();
        @(posedge clk);
        model_update();
        #1;
        orr = {flush, new_pc, ex_mc_done, ex_mc_abort, busy};
        er  = model_regs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stallreq_id = 0; stallreq_ex = 0; ex_mc_start = 0; ex_mc_len = 0;
        excp_req = 0; excp_pc = 0;
        model_reset();
        #2;
        checks++;
        if ({stall, flush, new_pc, ex_mc_done, ex_mc_abort, busy} !== 42'h0) begin
            errors++;
            $display("FAIL reset: got %h want 0", {stall, flush, new_pc, ex_mc_done, ex_mc_abort, busy});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stall_req();
        logic [5:0] os, es; logic [35:0] orr, er;
        logic [1:0] pat [6] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 6; i++) begin
            run_cycle(pat[i][0], pat[i][1], 0, 0, 0, 0, os, es, orr, er);
            checks++;
            if (os !== es) begin errors++; $display("FAIL stall_req[%0d]: stall got %b want %b", i, os, es); end
            checks++;
            if (orr !== er) begin errors++; $display("FAIL stall_req_regs[%0d]: got %h want %h", i, orr, er); end
        end
    endtask

    task automatic test_mc();
        logic [5:0] os, es; logic [35:0] orr, er;
        logic [5:0] lens [5] = '{6'd4, 6'd0, 6'd1, 6'd2, 6'd7};
        int done_seen;
        for (int k = 0; k < 5; k++) begin
            done_seen = 0;
            for (int c = 0; c < 9; c++) begin
                run_cycle(c == 2, 0, c == 0, lens[k], 0, 0, os, es, orr, er);
                if (ex_mc_done) done_seen++;
                checks++;
                if (os !== es) begin errors++; $display("FAIL mc len=%0d c=%0d: stall got %b want %b", lens[k], c, os, es); end
                checks++;
                if (orr !== er) begin errors++; $display("FAIL mc_regs len=%0d c=%0d: got %h want %h", lens[k], c, orr, er); end
            end
            checks++;
            if (done_seen != 1) begin errors++; $display("FAIL mc_done_count len=%0d: got %0d want 1", lens[k], done_seen); end
        end
    endtask

    task automatic test_abort();
        logic [5:0] os, es; logic [35:0] orr, er;
        int done_seen = 0, abort_seen = 0;
        for (int c = 0; c < 16; c++) begin
            run_cycle(0, c == 5, c == 0 || c == 4, 6'd10, c == 2, 32'h0000_0020, os, es, orr, er);
            if (ex_mc_done) done_seen++;
            if (ex_mc_abort) abort_seen++;
            checks++;
            if (os !== es) begin errors++; $display("FAIL abort c=%0d: stall got %b want %b", c, os, es); end
            checks++;
            if (orr !== er) begin errors++; $display("FAIL abort_regs c=%0d: got %h want %h", c, orr, er); end
        end
        checks++;
        if (done_seen != 0 || abort_seen != 1) begin
            errors++;
            $display("FAIL abort_pulses: got done=%0d abort=%0d want done=0 abort=1", done_seen, abort_seen);
        end
    endtask

    task automatic test_flush_double();
        logic [5:0] os, es; logic [35:0] orr, er;
        int flush_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            run_cycle(c == 2, c == 3, c == 2, 6'd5, c == 0 || c == 1, (c == 0) ? 32'h1234_5678 : 32'hdead_beef,
                      os, es, orr, er);
            if (flush) flush_cycles++;
            checks++;
            if (os !== es) begin errors++; $display("FAIL flush2 c=%0d: stall got %b want %b", c, os, es); end
            checks++;
            if (orr !== er) begin errors++; $display("FAIL flush2_regs c=%0d: got %h want %h", c, orr, er); end
        end
        checks++;
        if (flush_cycles != FC) begin errors++; $display("FAIL flush_len: got %0d want %0d", flush_cycles, FC); end
        checks++;
        if (new_pc !== 32'h1234_5678) begin errors++; $display("FAIL flush_pc_hold: got %h want 12345678", new_pc); end
    endtask

    task automatic test_same_cycle();
        logic [5:0] os, es; logic [35:0] orr, er;
        for (int c = 0; c < 6; c++) begin
            run_cycle(0, 0, c == 0, 6'd6, c == 0, 32'h0000_4000, os, es, orr, er);
            checks++;
            if (os !== es) begin errors++; $display("FAIL same_cycle c=%0d: stall got %b want %b", c, os, es); end
            checks++;
            if (orr !== er) begin errors++; $display("FAIL same_cycle_regs c=%0d: got %h want %h", c, orr, er); end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] os, es; logic [35:0] orr, er;
        for (int c = 0; c < 5; c++) run_cycle(0, 0, c == 0, 6'd10, 0, 0, os, es, orr, er);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({stall, flush, new_pc, ex_mc_done, ex_mc_abort, busy} !== 42'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", {stall, flush, new_pc, ex_mc_done, ex_mc_abort, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            run_cycle(0, 0, 0, 0, 0, 0, os, es, orr, er);
            checks++;
            if (os !== es || orr !== er) begin
                errors++;
                $display("FAIL reset_mid_after c=%0d: got %b/%h want %b/%h", c, os, orr, es, er);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] os, es; logic [35:0] orr, er;
        for (int c = 0; c < 400; c++) begin
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                      6'($urandom_range(0, 12)), $urandom_range(0, 19) == 0, $urandom, os, es, orr, er);
            checks++;
            if (os !== es) begin errors++; $display("FAIL random c=%0d: stall got %b want %b", c, os, es); end
            checks++;
            if (orr !== er) begin errors++; $display("FAIL random_regs c=%0d: got %h want %h", c, orr, er); end
        end
    endtask

    initial begin
        test_reset();
        test_stall_req();
        test_mc();
        test_abort();
        test_flush_double();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
